fifo_drain_serializer: RTL

Read-side consumer for the 64-bit, 64-deep RAM FIFO. It pops 64-bit words whenever the FIFO reports non-empty and serializes each word into four 16-bit beats, least-significant beat first, on a valid/ready stream. It also marks frame boundaries every FRAME_WORDS words and keeps a running word count. It sits between the FIFO dequeue port and the downstream packet/link logic.

---
 rtl/fifo_drain_serializer.sv | 85 ++++++++
 1 files changed

// File: rtl/fifo_drain_serializer.sv
// Drains a first-word-fall-through 64-bit FIFO and serializes each word into
// four 16-bit valid/ready beats (LSB beat first), with frame marking and a word count.
module fifo_drain_serializer #(
    parameter int OUT_W       = 16,
    parameter int FRAME_WORDS = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [63:0]      fifo_rdata,
    output logic             fifo_ren,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [31:0]      words_sent,
    output logic             dbg_state
);

    // Stream handshake: a beat transfers on any rising edge where m_valid and
    // m_ready are both high; while m_valid=1 and m_ready=0 the beat is held.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [7:0] FRAME_LAST = 8'(FRAME_WORDS - 1);

    state_t      state;
    logic [63:0] hold_q;
    logic [1:0]  beat_idx;
    logic [7:0]  frame_cnt;
    logic        word_done;

    assign word_done = (state == SEND) && m_ready && (beat_idx == 2'd3);

    // Gated by rstn so no pop can be issued while the block is held in reset.
    assign fifo_ren = rstn && enable && !fifo_empty &&
                      ((state == IDLE) || word_done);

    assign m_valid   = (state == SEND);
    assign m_data    = m_valid ? hold_q[OUT_W*int'(beat_idx) +: OUT_W] : '0;
    assign m_last    = m_valid && (beat_idx == 2'd3) && (frame_cnt == FRAME_LAST);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            hold_q     <= '0;
            beat_idx   <= '0;
            frame_cnt  <= '0;
            words_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_ren) begin
                        hold_q   <= fifo_rdata;
                        beat_idx <= 2'd0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        if (beat_idx == 2'd3) begin
                            words_sent <= words_sent + 32'd1;
                            frame_cnt  <= (frame_cnt == FRAME_LAST) ? 8'd0 : frame_cnt + 8'd1;
                            beat_idx   <= 2'd0;
                            // Back-to-back reload keeps m_valid high with no bubble.
                            if (fifo_ren) begin
                                hold_q <= fifo_rdata;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            beat_idx <= beat_idx + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
